// File: rtl/nibble_add_seq_if.sv
// Request/result bundle for the nibble-serial adder: two requester ports
// plus the shared result port.
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0;
  logic         req1;
  logic [W-1:0] op_a0;
  logic [W-1:0] op_b0;
  logic [W-1:0] op_a1;
  logic [W-1:0] op_b1;
  logic         sub0;
  logic         sub1;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] res;
  logic         c_out;
  logic         ovf;
  logic         res_valid;
  logic         res_id;
  logic         busy;

  modport master (
    output req0, req1, op_a0, op_b0, op_a1, op_b1, sub0, sub1,
    input  gnt0, gnt1, res, c_out, ovf, res_valid, res_id, busy
  );

  modport slave (
    input  req0, req1, op_a0, op_b0, op_a1, op_b1, sub0, sub1,
    output gnt0, gnt1, res, c_out, ovf, res_valid, res_id, busy
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Two-requester add/subtract unit that pushes one 4-bit slice per cycle
// through a single adder, with round-robin arbitration between requesters.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  nibble_add_seq_if.slave   bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic            r_sub;
  logic            r_id;
  logic            r_carry;
  logic            r_last_id;
  logic            r_c_out;
  logic            r_ovf;
  logic            r_res_valid;
  logic            r_res_id;
  logic            r_busy;
  logic [IDXW-1:0] r_idx;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_grant;
  logic            w_gnt_id;
  logic [IDXW+1:0] w_ofs;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_s_nib;
  logic [4:0]      w_slice;
  logic            w_cout;
  logic            w_top_cin;

  // Arbitration and next-state; r_last_id holds the id served last.
  always_comb begin
    w_state_nx = r_state;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset_n) begin
          w_state_nx = IDLE;
        end else if (bus.req0 && bus.req1) begin
          if (r_last_id) begin
            w_gnt0 = 1'b1;
          end else begin
            w_gnt1 = 1'b1;
          end
          w_state_nx = ADD;
        end else if (bus.req0) begin
          w_gnt0     = 1'b1;
          w_state_nx = ADD;
        end else if (bus.req1) begin
          w_gnt1     = 1'b1;
          w_state_nx = ADD;
        end else begin
          w_state_nx = IDLE;
        end
      end
      ADD: begin
        if (r_idx == LAST_IDX) begin
          w_state_nx = DONE;
        end else begin
          w_state_nx = ADD;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_grant  = w_gnt0 | w_gnt1;
  assign w_gnt_id = w_gnt1;

  // The single 4-bit slice; subtract feeds the inverted B nibble with carry-in 1.
  assign w_ofs     = {r_idx, 2'b00};
  assign w_a_nib   = r_a[w_ofs +: 4];
  assign w_b_nib   = r_sub ? ~r_b[w_ofs +: 4] : r_b[w_ofs +: 4];
  assign w_slice   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
  assign w_s_nib   = w_slice[3:0];
  assign w_cout    = w_slice[4];
  assign w_top_cin = w_a_nib[3] ^ w_b_nib[3] ^ w_s_nib[3];

  // State register and busy flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
    end
  end

  // Operand capture, nibble-serial accumulation and result flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_res       <= {W{1'b0}};
      r_sub       <= 1'b0;
      r_id        <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= {IDXW{1'b0}};
      r_last_id   <= 1'b1;
      r_c_out     <= 1'b0;
      r_ovf       <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_grant) begin
        r_a       <= w_gnt_id ? bus.op_a1 : bus.op_a0;
        r_b       <= w_gnt_id ? bus.op_b1 : bus.op_b0;
        r_sub     <= w_gnt_id ? bus.sub1  : bus.sub0;
        r_carry   <= w_gnt_id ? bus.sub1  : bus.sub0;
        r_id      <= w_gnt_id;
        r_last_id <= w_gnt_id;
        r_idx     <= {IDXW{1'b0}};
      end else if (r_state == ADD) begin
        r_res[w_ofs +: 4] <= w_s_nib;
        r_carry           <= w_cout;
        r_idx             <= r_idx + IDXW'(1);
        if (r_idx == LAST_IDX) begin
          r_c_out     <= w_cout;
          r_ovf       <= w_top_cin ^ w_cout;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
        end else begin
          r_res_valid <= 1'b0;
        end
      end else begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.res       = r_res;
  assign bus.c_out     = r_c_out;
  assign bus.ovf       = r_ovf;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed and random checks of nibble_add_seq against a plain-arithmetic
// reference model, including arbitration, latency and mid-operation reset.
module tb_nibble_add_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  nibble_add_seq_if #(.NIBBLES(N)) bus ();

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, c_out, res} from ordinary two's-complement arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    if (!s) begin
      sum = {1'b0, a} + {1'b0, b};
      r   = sum[W-1:0];
      c   = sum[W];
      v   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {v, c, r};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [31:0] t;
    t = $urandom;
    return t[W-1:0];
  endfunction

  task automatic scramble_ops();
    bus.op_a0 = rnd();
    bus.op_b0 = rnd();
    bus.op_a1 = rnd();
    bus.op_b1 = rnd();
  endtask

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input bit scr);
    logic [W+1:0] e;
    int n;
    logic g;
    e = model(a, b, s);
    if (id == 0) begin
      bus.op_a0 = a; bus.op_b0 = b; bus.sub0 = s; bus.req0 = 1'b1;
    end else begin
      bus.op_a1 = a; bus.op_b1 = b; bus.sub1 = s; bus.req1 = 1'b1;
    end
    n = 0;
    g = 1'b0;
    while (!g && n < 20) begin
      @(negedge clk);
      n++;
      g = (id == 0) ? bus.gnt0 : bus.gnt1;
    end
    chk("gnt_seen", g, 1'b1);
    chk("gnt_lat", n, 1);
    chk("gnt_other", (id == 0) ? bus.gnt1 : bus.gnt0, 1'b0);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (scr) scramble_ops();
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      chk("busy", bus.busy, 1'b1);
      chk("gnt_in_busy", bus.gnt0 | bus.gnt1, 1'b0);
      if (k <= N) begin
        chk("valid_early", bus.res_valid, 1'b0);
      end else begin
        chk("valid", bus.res_valid, 1'b1);
        chk("res", bus.res, e[W-1:0]);
        chk("c_out", bus.c_out, e[W]);
        chk("ovf", bus.ovf, e[W+1]);
        chk("res_id", bus.res_id, id[0]);
      end
      @(posedge clk);
      #1;
      if (scr) scramble_ops();
    end
    @(negedge clk);
    chk("valid_pulse", bus.res_valid, 1'b0);
    chk("busy_idle", bus.busy, 1'b0);
    chk("res_hold", bus.res, e[W-1:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_res", bus.res, {W{1'b0}});
    chk("rst_c_out", bus.c_out, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    chk("rst_valid", bus.res_valid, 1'b0);
    chk("rst_res_id", bus.res_id, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_gnt", bus.gnt0 | bus.gnt1, 1'b0);
  endtask

  initial begin
    int g;
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b0;
    bus.sub0 = 1'b0;
    bus.sub1 = 1'b0;
    scramble_ops();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    reset_n  = 1'b1;

    do_op(0, 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    do_op(1, 16'h0005, 16'h0007, 1'b1, 1'b0);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(1, 16'h8000, 16'h0001, 1'b1, 1'b0);
    do_op(0, 16'h1234, 16'h1234, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op(int'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)), i[0]);
    end
    do_op(0, 16'h4321, 16'h1111, 1'b0, 1'b1);

    // Reset during the second ADD cycle aborts the operation.
    bus.op_a0 = 16'h00FF;
    bus.op_b0 = 16'h0F0F;
    bus.sub0  = 1'b0;
    bus.req0  = 1'b1;
    @(negedge clk);
    chk("abort_gnt", bus.gnt0, 1'b1);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    bus.req1 = 1'b1;
    bus.op_a1 = 16'h0042;
    bus.op_b1 = 16'h0013;
    bus.sub1  = 1'b1;
    @(negedge clk);
    chk("rst_gnt_low", bus.gnt0 | bus.gnt1, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_op(1, 16'h0042, 16'h0013, 1'b1, 1'b0);

    // Both requesters held from reset: grants alternate every N+2 cycles.
    reset_n  = 1'b0;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.sub0 = 1'b0;
    bus.sub1 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    g = 0;
    for (int cyc = 0; cyc < 4 * (N + 2); cyc++) begin
      @(negedge clk);
      chk("arb_both", bus.gnt0 & bus.gnt1, 1'b0);
      chk("arb_busy", (bus.gnt0 | bus.gnt1) & bus.busy, 1'b0);
      if (bus.gnt0 | bus.gnt1) begin
        chk("arb_id", bus.gnt1, g % 2);
        chk("arb_cyc", cyc, g * (N + 2));
        g++;
      end
      @(posedge clk);
      #1;
    end
    chk("arb_count", g, 4);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (N + 3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset_n  input  1  reset, synchronous, active-low, sampled on rising clk.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 op_a0, op_b0, op_a1, op_b1  input  W each  operands for requester 0 / 1.
REQ-006 sub0, sub1  input  1 each  1 = compute A-B, 0 = compute A+B.
REQ-007 gnt0, gnt1  output  1 each  combinational accept strobe; operands are captured on the edge that ends a gnt cycle.
REQ-008 res  output  W  result register.
REQ-009 c_out  output  1  final carry: add = carry out; subtract = 1 for no borrow.
REQ-010 ovf  output  1  two's-complement signed overflow of the final slice.
REQ-011 res_valid  output  1  one-cycle pulse marking a new result.
REQ-012 res_id  output  1  requester index owning the current res.
REQ-013 busy  output  1  high in states ADD and DONE.

Function
REQ-014 The block SHALL contain exactly one internal 4-bit adder slice: inputs a_nib[3:0], b_nib[3:0], cin; outputs s_nib[3:0], cout. All arithmetic SHALL be performed nibble-serially through this slice.
REQ-015 The FSM SHALL have three states: IDLE, ADD, DONE.
REQ-016 IDLE, no request: the FSM SHALL stay in IDLE, and gnt0 and gnt1 SHALL both be 0.
REQ-017 IDLE, one request: the FSM SHALL assert that requester's gnt for the cycle.
REQ-018 IDLE, both requests: the FSM SHALL grant the requester not served last (round-robin pointer); after reset the pointer SHALL favour requester 0.
REQ-019 At most one gnt SHALL be high in any cycle, and gnt SHALL be 0 outside IDLE.
REQ-020 On the edge ending a gnt cycle, the block SHALL:
  - latch A, B, the sub flag and the id;
  - load the carry register with the sub flag;
  - clear the nibble index to 0;
  - update the round-robin pointer to the granted id;
  - move the FSM to ADD.
REQ-021 For a subtract operation, b_nib SHALL be the bitwise inverse of the latched B nibble.
REQ-022 In ADD, for nibble index i, the slice SHALL add A[4i+3:4i], the (possibly inverted) B nibble and the carry register; s_nib SHALL be written to res[4i+3:4i], cout to the carry register, and i SHALL increment.
REQ-023 In ADD, the remaining bits of res SHALL keep their values; partial results are visible on res during ADD.
REQ-024 On the edge that processes i = NIBBLES-1, the block SHALL:
  - write c_out from cout;
  - write ovf as the XOR of the carry into and out of the top bit;
  - write res_id;
  - move the FSM to DONE.
REQ-025 Latency: with gnt high in cycle T, ADD SHALL occupy cycles T+1..T+NIBBLES, and res_valid SHALL be 1 in exactly cycle T+NIBBLES+1 (DONE).
REQ-026 DONE SHALL last one cycle, then the FSM SHALL return to IDLE.
REQ-027 Requests SHALL be sampled only in IDLE, giving a minimum issue interval of NIBBLES+2 cycles.
REQ-028 res, c_out, ovf and res_id SHALL hold their values from DONE until the next operation's ADD cycles begin writing.
REQ-029 A requester SHALL hold req and operands stable until its gnt; a req dropped before gnt SHALL be ignored with no side effect.
REQ-030 Operand input changes during ADD or DONE SHALL NOT affect the operation in flight.

Reset
REQ-031 With reset_n = 0 at a rising edge, the block SHALL set: state IDLE; res = 0; c_out = 0; ovf = 0; res_valid = 0; res_id = 0; busy = 0; carry = 0; nibble index = 0; round-robin pointer favouring requester 0.
REQ-032 gnt0 and gnt1 SHALL be 0 whenever reset_n = 0.
REQ-033 A reset asserted during ADD or DONE SHALL abort the operation; no res_valid SHALL be emitted for it.
REQ-034 The first grant SHALL be possible in the first cycle with reset_n = 1.

Verification
REQ-035 Add, NIBBLES=4: req0 with A=0x1234, B=0x0FCD, sub0=0 -> gnt0 in cycle T; res_valid in T+5; res=0x2201; c_out=0; ovf=0; res_id=0.
REQ-036 Subtract: req1 with A=0x0005, B=0x0007, sub1=1 -> res=0xFFFE; c_out=0 (borrow); ovf=0; res_id=1.
REQ-037 Carry and overflow: req0 with A=0xFFFF, B=0x0001, add -> res=0x0000, c_out=1, ovf=0. Then A=0x7FFF, B=0x0001 -> res=0x8000, c_out=0, ovf=1.
REQ-038 Arbitration: req0 and req1 held high continuously from reset -> grants alternate 0,1,0,1, spaced 6 cycles apart; gnt never asserts during busy.
REQ-039 Reset mid-operation: reset_n low in the 2nd ADD cycle -> next cycle all outputs at reset values, no res_valid. A following req1 is granted in the first cycle after reset_n returns high.
REQ-040 Operand stability: change op_a0 and op_b0 every cycle during ADD -> res equals the sum of the values latched at gnt.
